// File: rtl/alu_seq_pkg.sv
// Shared definitions for the handshaked ALU: opcode values, PSR bit positions
// and the sequencer state encoding.
package alu_seq_pkg;

  localparam logic [7:0] OP_AND    = 8'h01;
  localparam logic [7:0] OP_OR     = 8'h02;
  localparam logic [7:0] OP_XOR    = 8'h03;
  localparam logic [7:0] OP_ADD    = 8'h05;
  localparam logic [7:0] OP_ADDU   = 8'h06;
  localparam logic [7:0] OP_SUB    = 8'h09;
  localparam logic [7:0] OP_CMP    = 8'h0B;
  localparam logic [7:0] OP_MOV    = 8'h0D;
  localparam logic [7:0] OP_MUL    = 8'h0E;
  localparam logic [7:0] OP_LOAD   = 8'h40;
  localparam logic [7:0] OP_STOR   = 8'h44;
  localparam logic [7:0] OP_DEC    = 8'h4F;
  localparam logic [7:0] OP_LSHI_L = 8'h80;
  localparam logic [7:0] OP_LSHI_R = 8'h81;
  localparam logic [7:0] OP_LSH    = 8'h84;
  // LUI matches on the upper nibble only (0xF0..0xFF)
  localparam logic [3:0] OP_LUI_HI = 4'hF;

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

  typedef enum logic {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per clock.
// done is raised during the final iteration so the parent can write that same edge.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic             running;
  logic             fin;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = b_sh[0] ? acc + a_sh : acc;
  assign done     = fin || (running && (cnt == CNT_LAST));
  // once finished, acc is frozen and presented directly
  assign product  = fin ? acc : acc_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      running <= 1'b0;
      fin     <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
    end else if (start) begin
      running <= 1'b1;
      fin     <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      a_sh    <= a;
      b_sh    <= b;
    end else if (running) begin
      acc  <= acc_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
      if (cnt == CNT_LAST) begin
        running <= 1'b0;
        fin     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU between register read and writeback: op decode, PSR,
// single-entry output slot and the IDLE/MULT sequencer.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] rdata_a,
  input  logic [WIDTH-1:0] rdata_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       psr_out,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic [4:0]       psr;
  logic             slot_free;
  logic             accept;
  logic             mul_start;
  logic             op_complete;
  logic             mul_complete;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] op_res;
  logic [4:0]       op_psr;

  assign slot_free    = !out_valid || out_ready;
  assign in_ready     = (state == IDLE) && slot_free;
  assign accept       = in_valid && in_ready;
  assign mul_start    = accept && (opcode == OP_MUL);
  assign op_complete  = accept && (opcode != OP_MUL);
  assign mul_complete = (state == MULT) && mul_done && slot_free;
  assign busy         = (state == MULT);
  assign psr_out      = psr;

  assign sum   = {1'b0, rdata_a} + {1'b0, rdata_b};
  assign diff  = rdata_a - rdata_b;
  assign b_mag = rdata_b[MSB] ? -rdata_b : rdata_b;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (rdata_a),
    .b       (rdata_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    op_res = '0;
    op_psr = psr;
    case (opcode)
      OP_AND:  op_res = rdata_a & rdata_b;
      OP_OR:   op_res = rdata_a | rdata_b;
      OP_XOR:  op_res = rdata_a ^ rdata_b;
      OP_ADD, OP_ADDU: begin
        op_res        = sum[MSB:0];
        op_psr[PSR_C] = sum[WIDTH];
        op_psr[PSR_F] = (rdata_a[MSB] == rdata_b[MSB]) && (sum[MSB] != rdata_a[MSB]);
      end
      OP_SUB: begin
        op_res        = diff;
        op_psr[PSR_C] = rdata_a < rdata_b;
        op_psr[PSR_F] = (rdata_a[MSB] != rdata_b[MSB]) && (diff[MSB] != rdata_a[MSB]);
      end
      OP_CMP: begin
        op_psr[PSR_Z] = rdata_a == rdata_b;
        op_psr[PSR_L] = rdata_a > rdata_b;
        op_psr[PSR_N] = $signed(rdata_a) > $signed(rdata_b);
      end
      OP_MOV:            op_res = rdata_b;
      OP_LOAD, OP_STOR:  op_res = rdata_a;
      OP_DEC:            op_res = rdata_a - WIDTH'(1);
      OP_LSHI_L:         op_res = rdata_a << rdata_b[SHW-1:0];
      OP_LSHI_R:         op_res = rdata_a >> rdata_b[SHW-1:0];
      OP_LSH: begin
        // magnitude >= WIDTH (including the most negative B) flushes to zero
        if (b_mag < WIDTH'(WIDTH))
          op_res = rdata_b[MSB] ? (rdata_a >> b_mag[SHW-1:0])
                                : (rdata_a << b_mag[SHW-1:0]);
      end
      default: begin
        if (opcode[7:4] == OP_LUI_HI)
          op_res = {rdata_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      result    <= '0;
      psr       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (op_complete) begin
        result    <= op_res;
        psr       <= op_psr;
        out_valid <= 1'b1;
      end else if (mul_complete) begin
        result    <= mul_product;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE:    if (mul_start) state <= MULT;
        MULT:    if (mul_complete) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the datapath ALU.
- Executes the existing 8-bit opcode set on WIDTH-bit operands, plus a new multi-cycle unsigned multiply.
- Sits between register-file read and writeback: a registered result with valid/ready on both sides, so stalls in writeback back-pressure decode.
- The processor status register (PSR) lives here and updates only on completion of flag-setting ops.

## Interface
Parameters:
- WIDTH, 16, operand/result width; even, ≥8.
- SHW, $clog2(WIDTH), localparam: shift-amount bits.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  opcode/operands valid.
- in_ready  out  1  block accepts this cycle.
- opcode  in  8  operation select.
- rdata_a  in  WIDTH  operand A.
- rdata_b  in  WIDTH  operand B.
- out_valid  out  1  result/psr_out valid.
- out_ready  in  1  writeback consumes result.
- result  out  WIDTH  registered result.
- psr_out  out  5  {N,Z,F,L,C} = bits [4:0].
- busy  out  1  multiply in progress.

## Operation
Opcodes; the result is written at completion:
- 0x01 AND, 0x02 OR, 0x03 XOR.
- 0x05 ADD and 0x06 ADDU: A+B.
- 0x09 SUB: A−B.
- 0x0B CMP: result 0.
- 0x0D MOV: B.
- 0x0E MUL: low WIDTH bits of unsigned A×B.
- 0x40 LOAD and 0x44 STOR: A. 0x4F DEC: A−1.
- 0x80 LSHI left: A<<B[SHW-1:0]. 0x81 LSHI right: logical A>>B[SHW-1:0].
- 0x84 LSH: B is signed two's-complement; B≥0 gives A<<B, B<0 gives logical A>>(−B). |B|≥WIDTH gives 0.
- 0xF_ LUI: {B[WIDTH/2-1:0], WIDTH/2 zeros}.
- Any other opcode: result 0, PSR unchanged.

PSR (internal register, driven on psr_out); bits not listed hold their value:
- ADD, ADDU: C = carry out of the MSB. F = signed overflow (A,B MSBs equal and result MSB differs).
- SUB: C = borrow (A<B unsigned). F = signed overflow (A,B MSBs differ and result MSB ≠ A MSB).
- CMP: Z = (A==B). L = A>B unsigned. N = A>B signed. C and F unchanged.
- All other ops, including MUL, leave PSR unchanged.

FSM states:
- IDLE: accepts on in_valid && in_ready. Non-MUL ops complete at the same edge. MUL latches A and B, clears the accumulator and cnt, and moves to MULT.
- MULT: iterative shift-add, one multiplier bit per cycle, cnt 0..WIDTH−1. After the WIDTH-th iteration the product is final.
  - If the output slot is free (!out_valid || out_ready), the result is written and the FSM returns to IDLE.
  - Otherwise the FSM holds in MULT with the product frozen.
- busy = (state==MULT).

Output slot and handshake:
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational; in_valid has no combinational path to in_ready.
- On completion: result and PSR are written, and out_valid is set to 1.
- out_valid clears on out_ready when no new completion occurs at the same edge. A simultaneous consume and complete leaves out_valid=1 with the new data.
- result and psr_out hold steady while out_valid && !out_ready.

Reset behaviour:
- Outputs after reset: result=0, psr_out=0, out_valid=0, busy=0, in_ready=1, state=IDLE.
- Reset asserted mid-MUL aborts the multiply and discards it; no result is emitted.

## Timing
- Single-cycle ops: accepted at edge N, so out_valid=1 after edge N, i.e. visible in cycle N+1.
- Back-to-back throughput is 1 op/cycle when out_ready is held at 1.
- MUL: accepted at edge N, out_valid after edge N+WIDTH when unstalled. in_ready=0 for the WIDTH cycles between.
- A MUL stalled by a full slot completes on the first edge where out_ready=1 (or !out_valid).
- psr_out changes only at the same edge as result; it never leads or lags it.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams (OP_AND … OP_LUI_HI).
  - PSR bit indices PSR_C=0, PSR_L=1, PSR_F=2, PSR_Z=3, PSR_N=4.
  - state encoding {IDLE, MULT}.
- Sub-module alu_mul_seq(WIDTH) holds the shift-add multiplier:
  - inputs: start, a, b.
  - outputs: done, product[WIDTH-1:0].
  - cnt and accumulator live inside it.
- The parent holds the combinational op decode, the PSR, the output slot and the FSM.

## Test plan
- WIDTH=16, reset, then ADD 0x7FFF+0x0001 with out_ready=1 -> one cycle later result=0x8000, F=1, C=0, out_valid=1; all outputs were 0 while reset was held.
- CMP A=0xFFFF, B=0x0001 -> Z=0, L=1, N=0; C and F keep their prior values; result=0.
- LSH A=0x00F0, B=0xFFFC -> 0x000F. B=0x0004 -> 0x0F00. B=0x0010 -> 0x0000.
- MUL 0x0012×0x0034 with out_ready=1 -> out_valid exactly 16 cycles after accept, result=0x03A8. in_ready=0 and busy=1 throughout; PSR unchanged.
- Back-pressure:
  - Hold out_ready=0 after an AND completes: result is stable and in_ready=0.
  - A second op offered meanwhile is not accepted.
  - Raise out_ready: the first result is consumed and the second op is accepted at that same edge.
- Start a MUL, assert reset at iteration 5 -> next cycle state=IDLE, out_valid=0, psr_out=0, in_ready=1; no result is ever emitted. Also run the MUL directed case at WIDTH=8 and WIDTH=32.
